// File: rtl/uart_rx_pkg.sv
// Shared constants and the baud divisor helper for the UART receive controller.
package uart_rx_pkg;

  localparam int OVS       = 16;
  localparam int DATA_W    = 8;
  localparam int ERR_CNT_W = 8;

  // Rounded clk cycles per oversampling tick.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + (OVS / 2) * baud) / (OVS * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  // Storage and pointers; caller only pushes when not full or popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x sampling tick, byte assembly, valid/ready byte buffer and status.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  output logic                 sampling,
  input  logic                 catch_bit,
  input  logic [3:0]           catch_bit_cnt,
  input  logic                 shift_rst,
  input  logic                 i_rx_complete,
  input  logic                 i_rx_error,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overflow,
  output logic [ERR_CNT_W-1:0] o_frame_err_cnt,
  input  logic                 i_clr_status
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [CNT_W-1:0]     r_tick_cnt;
  logic [CNT_W-1:0]     w_tick_nxt;
  logic                 r_sampling;
  logic [DATA_W-1:0]    r_asm;
  logic                 r_overflow;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;

  always_comb begin
    w_tick_nxt = '0;
    if (!i_enable) begin
      w_tick_nxt = '0;
    end else if (r_tick_cnt == CNT_LAST) begin
      w_tick_nxt = '0;
    end else begin
      w_tick_nxt = r_tick_cnt + CNT_W'(1);
    end
  end

  // sampling is registered off the next count so it is high while the counter sits at DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_sampling <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_sampling <= i_enable & (w_tick_nxt == CNT_LAST);
    end
  end

  // Bit indices outside 0..7 are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else if (shift_rst) begin
      r_asm <= '0;
    end else if (!catch_bit_cnt[3]) begin
      r_asm[catch_bit_cnt[2:0]] <= catch_bit;
    end
  end

  assign w_pop     = o_valid & i_ready;
  assign w_push_ok = i_rx_complete & (~w_full | w_pop);
  assign w_drop    = i_rx_complete & ~w_push_ok;

`ifdef UART_RX_FIFO_EN
  logic w_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_data  (r_asm),
    .o_data  (o_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_valid = ~w_empty;
`else
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_push_ok) begin
      r_hold_data  <= r_asm;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign w_full  = r_hold_valid;
  assign o_valid = r_hold_valid;
  assign o_data  = r_hold_data;
`endif

  // A new overflow or error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_status) begin
        r_overflow <= 1'b0;
      end
      if (i_clr_status) begin
        r_err_cnt <= {{(ERR_CNT_W-1){1'b0}}, i_rx_error};
      end else if (i_rx_error && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign sampling        = r_sampling;
  assign o_overflow      = r_overflow;
  assign o_frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: randomized frames against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DIV_M = (50_000_000 + 8 * 115200) / (16 * 115200);
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH_M = 4;
`else
  localparam int DEPTH_M = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_enable;
  logic       sampling;
  logic       catch_bit;
  logic [3:0] catch_bit_cnt;
  logic       shift_rst;
  logic       i_rx_complete;
  logic       i_rx_error;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_overflow;
  logic [7:0] o_frame_err_cnt;
  logic       i_clr_status;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  byte unsigned m_byte;
  bit           m_ovf;
  int           m_err;
  bit           rand_ready;

  uart_rx_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .sampling        (sampling),
    .catch_bit       (catch_bit),
    .catch_bit_cnt   (catch_bit_cnt),
    .shift_rst       (shift_rst),
    .i_rx_complete   (i_rx_complete),
    .i_rx_error      (i_rx_error),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_overflow      (o_overflow),
    .o_frame_err_cnt (o_frame_err_cnt),
    .i_clr_status    (i_clr_status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_err = 0;
  endtask

  // One clock with the current inputs; the model applies the buffer/status rules for that cycle.
  task automatic cyc();
    bit pop_m;
    bit acc_m;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    pop_m = (mq.size() > 0) && i_ready;
    acc_m = i_rx_complete && ((mq.size() < DEPTH_M) || pop_m);
    @(posedge clk); #1;
    if (pop_m) void'(mq.pop_front());
    if (acc_m) mq.push_back(m_byte);
    if (i_rx_complete && !acc_m) m_ovf = 1'b1;
    else if (i_clr_status) m_ovf = 1'b0;
    if (i_clr_status) m_err = i_rx_error ? 1 : 0;
    else if (i_rx_error && m_err < 255) m_err++;
  endtask

  // FSM-like frame: idle, bits 0..7 each held two cycles, then a complete (kind 0) or error (kind 1) pulse.
  task automatic drive_frame(input byte unsigned b, input int kind, input bit ready_at_end);
    shift_rst = 1'b1; i_rx_complete = 1'b0; i_rx_error = 1'b0;
    cyc();
    shift_rst = 1'b0;
    m_byte = b;
    for (int k = 0; k < 8; k++) begin
      catch_bit_cnt = 4'(k);
      catch_bit = b[k];
      cyc();
      cyc();
    end
    if (ready_at_end) i_ready = 1'b1;
    if (kind == 0) i_rx_complete = 1'b1;
    else i_rx_error = 1'b1;
    cyc();
    i_rx_complete = 1'b0; i_rx_error = 1'b0; shift_rst = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b0; catch_bit = 1'b0; catch_bit_cnt = 4'd0;
    shift_rst = 1'b1; i_rx_complete = 1'b0; i_rx_error = 1'b0; i_ready = 1'b0;
    i_clr_status = 1'b0; rand_ready = 1'b0; m_byte = 8'h00;
    model_clear();
    #3;
    checks++; if (sampling !== 1'b0) begin errors++; $display("FAIL reset_sampling got %0b exp 0", sampling); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", o_data); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", o_overflow); end
    checks++; if (o_frame_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", o_frame_err_cnt); end
  endtask

  // Counter starts at 0 after release, so the pulse is visible once it has counted up to DIV-1.
  task automatic test_tick();
    int n;
    int pulses;
    i_enable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (sampling) break;
    end
    checks++; if (n !== DIV_M - 1) begin errors++; $display("FAIL tick_first got %0d exp %0d", n, DIV_M - 1); end
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (n < 100) begin
        @(posedge clk); #1; n++;
        if (sampling) break;
      end
      checks++; if (n !== DIV_M) begin errors++; $display("FAIL tick_period got %0d exp %0d", n, DIV_M); end
    end
    i_enable = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (sampling) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL tick_disabled got %0d exp 0", pulses); end
    i_enable = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (sampling) break;
    end
    checks++; if (n !== DIV_M - 1) begin errors++; $display("FAIL tick_restart got %0d exp %0d", n, DIV_M - 1); end
  endtask

  task automatic test_assembly();
    byte unsigned b;
    i_ready = 1'b0;
    drive_frame(8'hA5, 0, 1'b0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL asm_valid got %0b exp 1", o_valid); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL asm_data got %0h exp a5", o_data); end
    i_ready = 1'b1;
    cyc();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL asm_pop got %0b exp 0", o_valid); end
    i_ready = 1'b0;
    b = 8'($urandom);
    drive_frame(b, 0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_data !== b) begin errors++; $display("FAIL asm_rand got %0b/%0h exp 1/%0h", o_valid, o_data, b); end
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    i_ready = 1'b1;
    drive_frame(8'($urandom), 1, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %0b exp 0", o_valid); end
    checks++; if (o_frame_err_cnt !== 8'd1) begin errors++; $display("FAIL ferr_cnt1 got %0d exp 1", o_frame_err_cnt); end
    for (int k = 0; k < 299; k++) begin
      i_rx_error = 1'b1;
      cyc();
    end
    i_rx_error = 1'b0;
    checks++; if (o_frame_err_cnt !== 8'd255) begin errors++; $display("FAIL ferr_sat got %0d exp 255", o_frame_err_cnt); end
    i_rx_error = 1'b1; i_clr_status = 1'b1;
    cyc();
    i_rx_error = 1'b0; i_clr_status = 1'b0;
    checks++; if (o_frame_err_cnt !== 8'd1) begin errors++; $display("FAIL ferr_clr_evt got %0d exp 1", o_frame_err_cnt); end
    i_clr_status = 1'b1;
    cyc();
    i_clr_status = 1'b0;
    checks++; if (o_frame_err_cnt !== 8'd0) begin errors++; $display("FAIL ferr_clr got %0d exp 0", o_frame_err_cnt); end
    i_ready = 1'b0;
  endtask

  task automatic test_overflow();
    i_ready = 1'b0;
    for (int v = 1; v <= DEPTH_M + 1; v++) drive_frame(8'(v), 0, 1'b0);
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", o_overflow); end
    m_byte = 8'hEE;
    i_rx_complete = 1'b1; i_clr_status = 1'b1;
    cyc();
    i_rx_complete = 1'b0; i_clr_status = 1'b0;
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_evt got %0b exp 1", o_overflow); end
    i_ready = 1'b1;
    for (int v = 1; v <= DEPTH_M; v++) begin
      checks++; if (o_valid !== 1'b1 || o_data !== 8'(v)) begin errors++; $display("FAIL ovf_order got %0b/%0h exp 1/%0h", o_valid, o_data, v); end
      cyc();
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b exp 0", o_valid); end
    i_ready = 1'b0; i_clr_status = 1'b1;
    cyc();
    i_clr_status = 1'b0;
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", o_overflow); end
  endtask

  task automatic test_full_push_pop();
    byte unsigned exp_q[$];
    byte unsigned b;
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH_M; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      drive_frame(b, 0, 1'b0);
    end
    drive_frame(8'h99, 0, 1'b1);
    i_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got %0b exp 0", o_overflow); end
    i_ready = 1'b1;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      checks++; if (o_valid !== 1'b1 || o_data !== b) begin errors++; $display("FAIL full_order got %0b/%0h exp 1/%0h", o_valid, o_data, b); end
      cyc();
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %0b exp 0", o_valid); end
    i_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    i_ready = 1'b0;
    drive_frame(8'h11, 0, 1'b0);
    drive_frame(8'h22, 0, 1'b0);
    drive_frame(8'h33, 1, 1'b0);
    shift_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      catch_bit_cnt = 4'(k); catch_bit = 1'b1;
      cyc(); cyc();
    end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL mrst_buf got %0b/%0h exp 0/00", o_valid, o_data); end
    checks++; if (o_overflow !== 1'b0 || o_frame_err_cnt !== 8'h00 || sampling !== 1'b0) begin
      errors++; $display("FAIL mrst_status got %0b/%0d/%0b exp 0/0/0", o_overflow, o_frame_err_cnt, sampling);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_frame(8'h3C, 0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h3C) begin errors++; $display("FAIL mrst_next got %0b/%0h exp 1/3c", o_valid, o_data); end
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      drive_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
      checks++; if (o_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid got %0b exp %0b", o_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (o_data !== mq[0]) begin errors++; $display("FAIL rand_data got %0h exp %0h", o_data, mq[0]); end
      end
      checks++; if (o_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf got %0b exp %0b", o_overflow, m_ovf); end
      checks++; if (o_frame_err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rand_errcnt got %0d exp %0d", o_frame_err_cnt, m_err); end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_assembly();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
